// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter in front of the register file's single write port.
// ALU results and load returns share one registered write per cycle. Loads queue
// in a circular FIFO; an ALU result aimed at a register that a queued load will
// also write is held back until that load drains, so writes land in program order.
// A starve counter forces a FIFO grant after STARVE_LIMIT consecutive ALU grants
// made while loads are waiting.
// Optional build macro WB_BYPASS_EN: when the FIFO is empty and the ALU is not
// granted, an arriving load loads the output register directly (one-cycle latency).
module wb_arbiter #(
    parameter int PROC_DATA_WIDTH        = 16,
    parameter int PROC_REGFILE_LOG2_DEEP = 5,
    parameter int FIFO_DEPTH             = 4,
    parameter int FIFO_LOG2_DEEP         = 2,
    parameter int STARVE_LIMIT           = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              alu_valid_i,
    output logic                              alu_ready_o,
    input  logic [PROC_REGFILE_LOG2_DEEP-1:0] alu_addr_i,
    input  logic [PROC_DATA_WIDTH-1:0]        alu_data_i,
    input  logic                              mem_valid_i,
    output logic                              mem_ready_o,
    input  logic [PROC_REGFILE_LOG2_DEEP-1:0] mem_addr_i,
    input  logic [PROC_DATA_WIDTH-1:0]        mem_data_i,
    output logic                              rf_write_en_o,
    output logic [PROC_REGFILE_LOG2_DEEP-1:0] rf_write_addr_o,
    output logic [PROC_DATA_WIDTH-1:0]        rf_write_data_o,
    output logic [FIFO_LOG2_DEEP:0]           mem_q_count_o,
    output logic                              busy_o
);

    localparam int CW = FIFO_LOG2_DEEP + 1;
    localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    // Load-return queue storage and bookkeeping
    logic [PROC_REGFILE_LOG2_DEEP-1:0] r_q_addr [FIFO_DEPTH];
    logic [PROC_DATA_WIDTH-1:0]        r_q_data [FIFO_DEPTH];
    logic [FIFO_LOG2_DEEP-1:0]         r_rd_ptr;
    logic [FIFO_LOG2_DEEP-1:0]         r_wr_ptr;
    logic [CW-1:0]                     r_count;
    logic [SW-1:0]                     r_starve;

    // Registered write port
    logic                              r_wr_en;
    logic [PROC_REGFILE_LOG2_DEEP-1:0] r_wr_addr;
    logic [PROC_DATA_WIDTH-1:0]        r_wr_data;

    logic w_full;
    logic w_hazard;
    logic w_force_mem;
    logic w_grant_alu;
    logic w_grant_fifo;
    logic w_bypass;
    logic w_mem_ready;
    logic w_push;

    // WAW check: an entry is live when its distance from the read pointer is below the count
    always_comb begin
        w_hazard = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_valid_i
                && ({1'b0, FIFO_LOG2_DEEP'(i) - r_rd_ptr} < r_count)
                && (r_q_addr[FIFO_LOG2_DEEP'(i)] == alu_addr_i)) begin
                w_hazard = 1'b1;
            end
        end
    end

    // Grant decision: ALU first unless blocked by hazard, full queue or starvation
    always_comb begin
        w_full       = (r_count == DEPTH_C);
        w_force_mem  = w_full || (r_starve == LIMIT_C);
        w_grant_alu  = !rst_i && alu_valid_i && !w_hazard && !w_force_mem;
        w_grant_fifo = !rst_i && !w_grant_alu && (r_count != '0);
        w_bypass     = 1'b0;
`ifdef WB_BYPASS_EN
        w_bypass     = !rst_i && (r_count == '0) && !w_grant_alu && mem_valid_i;
`endif
        // full check uses the pre-pop count: no push while full even if popping
        w_mem_ready  = !rst_i && (!w_full || w_bypass);
        w_push       = mem_valid_i && w_mem_ready && !w_bypass;
    end

    // Queue payload storage, written only on a push
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr] <= mem_addr_i;
            r_q_data[r_wr_ptr] <= mem_data_i;
        end
    end

    // Queue pointers and occupancy; reset discards any pending entries
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_grant_fifo) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_grant_fifo})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Starve counter: counts ALU grants taken while loads wait, saturating
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve <= '0;
        end else if (w_grant_fifo || (r_count == '0)) begin
            r_starve <= '0;
        end else if (w_grant_alu && (r_starve != LIMIT_C)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Output register: capture the granted write; register 0 is consumed but never written
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_grant_alu) begin
            r_wr_en   <= (alu_addr_i != '0);
            r_wr_addr <= alu_addr_i;
            r_wr_data <= alu_data_i;
        end else if (w_grant_fifo) begin
            r_wr_en   <= (r_q_addr[r_rd_ptr] != '0);
            r_wr_addr <= r_q_addr[r_rd_ptr];
            r_wr_data <= r_q_data[r_rd_ptr];
        end else if (w_bypass) begin
            r_wr_en   <= (mem_addr_i != '0);
            r_wr_addr <= mem_addr_i;
            r_wr_data <= mem_data_i;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    // Port outputs
    always_comb begin
        alu_ready_o     = w_grant_alu;
        mem_ready_o     = w_mem_ready;
        rf_write_en_o   = r_wr_en;
        rf_write_addr_o = r_wr_addr;
        rf_write_data_o = r_wr_data;
        mem_q_count_o   = r_count;
        busy_o          = (r_count != '0) || r_wr_en;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run,
// checked against a queue-based model of the arbitration rules.
module tb_wb_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int LOG2  = 2;
    localparam int LIMIT = 3;
    localparam int CW    = LOG2 + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          rf_en;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic [CW-1:0] q_count;
    logic          busy;

    always #5 clk = ~clk;

    wb_arbiter #(
        .PROC_DATA_WIDTH(DW),
        .PROC_REGFILE_LOG2_DEEP(AW),
        .FIFO_DEPTH(DEPTH),
        .FIFO_LOG2_DEEP(LOG2),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .alu_valid_i(alu_valid),
        .alu_ready_o(alu_ready),
        .alu_addr_i(alu_addr),
        .alu_data_i(alu_data),
        .mem_valid_i(mem_valid),
        .mem_ready_o(mem_ready),
        .mem_addr_i(mem_addr),
        .mem_data_i(mem_data),
        .rf_write_en_o(rf_en),
        .rf_write_addr_o(rf_addr),
        .rf_write_data_o(rf_data),
        .mem_q_count_o(q_count),
        .busy_o(busy)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    // Reference model state
    ent_t          mq[$];
    int            m_starve = 0;
    logic          m_en = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_alu_ready, m_mem_ready, m_grant_fifo, m_bypass;

    ent_t wlog[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic bit m_busy();
        return (mq.size() != 0) || m_en;
    endfunction

    // Decide this cycle's grant from the queue contents and the current inputs
    function automatic void model_eval();
        bit haz;
        bit fm;
        haz = 1'b0;
        foreach (mq[i]) if (alu_valid && mq[i].a == alu_addr) haz = 1'b1;
        fm = (mq.size() == DEPTH) || (m_starve == LIMIT);
        m_alu_ready  = !rst && alu_valid && !haz && !fm;
        m_grant_fifo = !rst && !m_alu_ready && (mq.size() > 0);
        m_bypass     = 1'b0;
`ifdef WB_BYPASS_EN
        m_bypass     = !rst && (mq.size() == 0) && !m_alu_ready && mem_valid;
`endif
        m_mem_ready  = !rst && ((mq.size() < DEPTH) || m_bypass);
    endfunction

    // Apply the decision taken by model_eval at the clock edge
    function automatic void model_commit();
        ent_t e;
        int   had;
        if (rst) begin
            mq.delete();
            m_starve = 0;
            m_en = 1'b0; m_addr = '0; m_data = '0;
            return;
        end
        had = mq.size();
        if (m_alu_ready) begin
            m_addr = alu_addr; m_data = alu_data; m_en = (alu_addr != 0);
            m_starve = (had > 0) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        end else if (m_grant_fifo) begin
            e = mq.pop_front();
            m_addr = e.a; m_data = e.d; m_en = (e.a != 0);
            m_starve = 0;
        end else if (m_bypass) begin
            m_addr = mem_addr; m_data = mem_data; m_en = (mem_addr != 0);
            m_starve = 0;
        end else begin
            m_en = 1'b0;
            m_starve = 0;
        end
        if (mem_valid && m_mem_ready && !m_bypass) begin
            e.a = mem_addr; e.d = mem_data;
            mq.push_back(e);
        end
    endfunction

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        ent_t e;
        @(posedge clk);
        model_commit();
        #1;
        if (rf_en === 1'b1) begin
            e.a = rf_addr; e.d = rf_data;
            wlog.push_back(e);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
        settle(); tick();
        rst = 1'b0;
        settle(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 16'h0055;
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 16'h0066;
        settle();
        n_checks++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got alu=%b mem=%b, expected 0 0", alu_ready, mem_ready);
        end
        tick();
        n_checks++;
        if ({rf_en, rf_addr, rf_data, q_count, busy} !== '0) begin
            n_fail++; $display("FAIL reset_state: got en=%b addr=%0d data=%h cnt=%0d busy=%b, expected all 0",
                               rf_en, rf_addr, rf_data, q_count, busy);
        end
        idle_inputs();
        settle(); tick();
    endtask

    task automatic test_alu_stream();
        logic [DW-1:0] exp_d;
        for (int i = 0; i < 3; i++) begin
            exp_d = DW'((i + 1) * 17);
            alu_valid = 1'b1; alu_addr = AW'(i + 1); alu_data = exp_d;
            settle();
            n_checks++;
            if (alu_ready !== 1'b1) begin
                n_fail++; $display("FAIL alu_stream_ready[%0d]: got %b, expected 1", i, alu_ready);
            end
            tick();
            n_checks++;
            if (rf_en !== 1'b1 || rf_addr !== AW'(i + 1) || rf_data !== exp_d || q_count !== '0) begin
                n_fail++; $display("FAIL alu_stream_write[%0d]: got en=%b addr=%0d data=%h cnt=%0d, expected 1 %0d %h 0",
                                   i, rf_en, rf_addr, rf_data, q_count, i + 1, exp_d);
            end
        end
        alu_valid = 1'b0;
        settle(); tick();
        n_checks++;
        if (rf_en !== 1'b0) begin
            n_fail++; $display("FAIL alu_stream_idle: got en=%b, expected 0", rf_en);
        end
    endtask

    task automatic test_load_burst();
        int   sent;
        bit   saw_full, acc_alu, acc_mem, ok;
        ent_t got[$];
        sent = 0; saw_full = 1'b0;
        do_reset();
        wlog.delete();
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = DW'($urandom);
        mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 16'hC000;
        for (int cyc = 0; cyc < 40 && (sent < 5 || mq.size() > 0 || m_en); cyc++) begin
            settle();
            n_checks++;
            if (alu_ready !== m_alu_ready || mem_ready !== m_mem_ready) begin
                n_fail++; $display("FAIL burst_ready: got alu=%b mem=%b, expected %b %b", alu_ready, mem_ready, m_alu_ready, m_mem_ready);
            end
            if (mq.size() == DEPTH && mem_valid) begin
                saw_full = 1'b1;
                n_checks++;
                if (mem_ready !== 1'b0) begin
                    n_fail++; $display("FAIL burst_full_blocks: got mem_ready=%b, expected 0", mem_ready);
                end
            end
            acc_alu = m_alu_ready; acc_mem = mem_valid && m_mem_ready;
            tick();
            n_checks++;
            if (rf_en !== m_en || rf_addr !== m_addr || rf_data !== m_data || q_count !== CW'(mq.size()) || busy !== m_busy()) begin
                n_fail++; $display("FAIL burst_out: got en=%b addr=%0d data=%h cnt=%0d busy=%b, expected %b %0d %h %0d %b",
                                   rf_en, rf_addr, rf_data, q_count, busy, m_en, m_addr, m_data, mq.size(), m_busy());
            end
            if (acc_alu) alu_data = DW'($urandom);
            if (acc_mem) begin
                sent++;
                if (sent < 5) begin
                    mem_addr = AW'(10 + sent); mem_data = DW'(16'hC000 + sent);
                end else begin
                    mem_valid = 1'b0; alu_valid = 1'b0;
                end
            end
        end
        idle_inputs();
        n_checks++;
        if (saw_full !== 1'b1 || sent != 5) begin
            n_fail++; $display("FAIL burst_progress: got saw_full=%b sent=%0d, expected 1 5", saw_full, sent);
        end
        foreach (wlog[i]) if (wlog[i].a >= 10 && wlog[i].a <= 14) got.push_back(wlog[i]);
        ok = (got.size() == 5);
        if (ok) foreach (got[i]) if (got[i].a != AW'(10 + i) || got[i].d != DW'(16'hC000 + i)) ok = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL burst_order: got %0d load writes (first addr %0d), expected r10..r14 in order",
                               got.size(), (got.size() > 0) ? got[0].a : 0);
        end
    endtask

    task automatic test_starve();
        bit exp_pat[11] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1};
        do_reset();
        for (int cyc = 0; cyc < 11; cyc++) begin
            alu_valid = 1'b1; alu_addr = 5'd20; alu_data = DW'($urandom);
            mem_valid = (cyc < 2); mem_addr = AW'(21 + cyc); mem_data = DW'(16'h5A00 + cyc);
            settle();
            n_checks++;
            if (alu_ready !== exp_pat[cyc] || mem_ready !== m_mem_ready) begin
                n_fail++; $display("FAIL starve_pattern[%0d]: got alu=%b mem=%b, expected %b %b",
                                   cyc, alu_ready, mem_ready, exp_pat[cyc], m_mem_ready);
            end
            tick();
            n_checks++;
            if (rf_en !== m_en || rf_addr !== m_addr || rf_data !== m_data || q_count !== CW'(mq.size()) || busy !== m_busy()) begin
                n_fail++; $display("FAIL starve_out[%0d]: got en=%b addr=%0d data=%h cnt=%0d, expected %b %0d %h %0d",
                                   cyc, rf_en, rf_addr, rf_data, q_count, m_en, m_addr, m_data, mq.size());
            end
        end
        idle_inputs();
        n_checks++;
        if (q_count !== '0) begin
            n_fail++; $display("FAIL starve_drained: got cnt=%0d, expected 0", q_count);
        end
    endtask

    task automatic test_waw();
        bit done, first;
        done = 1'b0; first = 1'b1;
        do_reset();
        wlog.delete();
        mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 16'hAAAA;
        settle(); tick();
        mem_valid = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 16'hBBBB;
        for (int cyc = 0; cyc < 10 && !done; cyc++) begin
            settle();
`ifndef WB_BYPASS_EN
            if (first) begin
                n_checks++;
                if (alu_ready !== 1'b0) begin
                    n_fail++; $display("FAIL waw_blocked: got alu_ready=%b, expected 0", alu_ready);
                end
            end
`endif
            first = 1'b0;
            n_checks++;
            if (alu_ready !== m_alu_ready) begin
                n_fail++; $display("FAIL waw_ready: got %b, expected %b", alu_ready, m_alu_ready);
            end
            done = m_alu_ready;
            tick();
        end
        idle_inputs();
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL waw_timeout: got no ALU accept in 10 cycles, expected accept");
        end
        settle(); tick(); settle(); tick();
        n_checks++;
        if (wlog.size() != 2 || wlog[0] != {5'd5, 16'hAAAA} || wlog[1] != {5'd5, 16'hBBBB}) begin
            n_fail++; $display("FAIL waw_order: got %0d writes first=%h, expected r5=AAAA then r5=BBBB",
                               wlog.size(), (wlog.size() > 0) ? wlog[0] : '0);
        end
    endtask

    task automatic test_addr0();
        do_reset();
        wlog.delete();
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 16'h1234;
        settle();
        n_checks++;
        if (alu_ready !== 1'b1) begin
            n_fail++; $display("FAIL addr0_alu_accept: got %b, expected 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        n_checks++;
        if (rf_en !== 1'b0) begin
            n_fail++; $display("FAIL addr0_alu_no_write: got en=%b, expected 0", rf_en);
        end
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 16'h5678;
        settle();
        n_checks++;
        if (mem_ready !== 1'b1) begin
            n_fail++; $display("FAIL addr0_mem_accept: got %b, expected 1", mem_ready);
        end
        tick();
        mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin settle(); tick(); end
        n_checks++;
        if (wlog.size() != 0 || q_count !== '0 || rf_en !== 1'b0) begin
            n_fail++; $display("FAIL addr0_no_write: got writes=%0d cnt=%0d en=%b, expected 0 0 0", wlog.size(), q_count, rf_en);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int cyc = 0; cyc < 3; cyc++) begin
            alu_valid = 1'b1; alu_addr = 5'd23; alu_data = DW'($urandom);
            mem_valid = 1'b1; mem_addr = AW'(24 + cyc); mem_data = DW'(16'hD000 + cyc);
            settle(); tick();
        end
        n_checks++;
        if (q_count !== 3'd3) begin
            n_fail++; $display("FAIL midop_fill: got cnt=%0d, expected 3", q_count);
        end
        rst = 1'b1;
        settle();
        n_checks++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            n_fail++; $display("FAIL midop_rst_ready: got alu=%b mem=%b, expected 0 0", alu_ready, mem_ready);
        end
        tick();
        n_checks++;
        if (q_count !== '0 || rf_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midop_rst_state: got cnt=%0d en=%b busy=%b, expected 0 0 0", q_count, rf_en, busy);
        end
        idle_inputs();
        wlog.delete();
        for (int i = 0; i < 6; i++) begin settle(); tick(); end
        n_checks++;
        if (wlog.size() != 0 || q_count !== '0) begin
            n_fail++; $display("FAIL midop_discarded: got writes=%0d cnt=%0d, expected 0 0", wlog.size(), q_count);
        end
    endtask

    task automatic test_random();
        bit alu_taken, mem_taken;
        alu_taken = 1'b1; mem_taken = 1'b1;
        do_reset();
        alu_valid = 1'b0; mem_valid = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            rst = ($urandom_range(0, 99) < 2);
            if (!alu_valid || alu_taken) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_addr  = AW'($urandom_range(0, 7));
                alu_data  = DW'($urandom);
            end
            if (!mem_valid || mem_taken) begin
                mem_valid = ($urandom_range(0, 2) != 0);
                mem_addr  = AW'($urandom_range(0, 7));
                mem_data  = DW'($urandom);
            end
            settle();
            n_checks++;
            if (alu_ready !== m_alu_ready || mem_ready !== m_mem_ready) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got alu=%b mem=%b, expected %b %b",
                                   cyc, alu_ready, mem_ready, m_alu_ready, m_mem_ready);
            end
            alu_taken = alu_valid && m_alu_ready;
            mem_taken = mem_valid && m_mem_ready;
            tick();
            n_checks++;
            if (rf_en !== m_en || rf_addr !== m_addr || rf_data !== m_data || q_count !== CW'(mq.size()) || busy !== m_busy()) begin
                n_fail++; $display("FAIL rand_out[%0d]: got en=%b addr=%0d data=%h cnt=%0d busy=%b, expected %b %0d %h %0d %b",
                                   cyc, rf_en, rf_addr, rf_data, q_count, busy, m_en, m_addr, m_data, mq.size(), m_busy());
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
        alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
        #1;
        test_reset();
        test_alu_stream();
        test_load_burst();
        test_starve();
        test_waw();
        test_addr0();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
